muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the MIPS pipeline's execute stage. It accepts MULT/MULTU/DIV/DIVU from E, runs a shift-add multiply or a restoring divide over WIDTH iterations, and holds F/D/E stalled while it runs. It then presents a 2×WIDTH result for the HI/LO write path, with a one-cycle done pulse.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_seq_if.sv | 32 +++
 rtl/muldiv_seq.sv | 173 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer: op codes, FSM states
// and the default operand width. The main decoder uses the same op codes.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Execute-stage view of the mul/div unit: request from E, stall back to the
// pipeline and the HI/LO result with its done pulse.
interface muldiv_seq_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);

  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             cancel;
  logic             stall_mdE;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side issues ops and consumes results
  modport master (
    output startE, opE, srcaE, srcbE, cancel,
    input  stall_mdE, busy, done, hi, lo
  );

  // Sequencer side
  modport slave (
    input  startE, opE, srcaE, srcbE, cancel,
    output stall_mdE, busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer. Signed ops are run on magnitudes and
// sign-corrected in a dedicated FIX cycle; HI/LO are only written on entry
// to DONE so they stay stable between results.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave md
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  md_op_e             op_q, op_d;
  logic               negRes_q, negRes_d;
  logic               negRem_q, negRem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               accept;
  logic               startSigned;
  logic               startIsDiv;
  logic               startDivZero;
  logic               signA;
  logic               signB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic               opIsDiv;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divTrial;
  logic [WIDTH+1:0]   divDiff;
  logic [2*WIDTH-1:0] divNext;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  // Issue decode: MULTU/DIVU (op bit 0 set) use the raw operands
  assign accept       = (state_q == S_IDLE) && md.startE && !md.cancel;
  assign startSigned  = ~md.opE[0];
  assign startIsDiv   = md.opE[1];
  assign startDivZero = startIsDiv && (md.srcbE == '0);
  assign signA        = startSigned & md.srcaE[WIDTH-1];
  assign signB        = startSigned & md.srcbE[WIDTH-1];
  assign magA         = signA ? -md.srcaE : md.srcaE;
  assign magB         = signB ? -md.srcbE : md.srcbE;
  assign opIsDiv      = (op_q == MD_DIV) || (op_q == MD_DIVU);

  // Shift-add step: upper half accumulates the multiplicand, whole acc shifts right
  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mulNext = {mulSum, acc_q[WIDTH-1:1]};

  // Restoring step: the trial remainder needs one extra bit before the subtract
  assign divTrial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign divDiff  = {1'b0, divTrial} - {2'b00, opnd_q};
  assign divNext  = divDiff[WIDTH+1]
                  ? {divTrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                  : {divDiff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  // Sign correction applied while in FIX; remainder follows the dividend's sign
  assign prodFix = negRes_q ? -acc_q : acc_q;
  assign quotFix = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign remFix  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // Stall is combinational from startE so the issuing instruction holds in E
  assign md.stall_mdE = !md.cancel &&
                        (((state_q == S_IDLE) && md.startE) ||
                         (state_q == S_BUSY) || (state_q == S_FIX));
  assign md.busy      = (state_q != S_IDLE);
  assign md.done      = !md.cancel && (state_q == S_DONE);
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;

  // FSM state and iteration counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; divide by zero skips straight to DONE, cancel wins everywhere
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = startDivZero ? S_DONE : S_BUSY;
          count_d = CW'(WIDTH - 1);
        end
      end
      S_BUSY: begin
        count_d = count_q - CW'(1);
        if (count_q == '0) state_d = S_FIX;
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (md.cancel) state_d = S_IDLE;
  end

  // Datapath registers: operands, accumulator and the HI/LO result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= MD_MULT;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      op_q     <= op_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Datapath next state: load on issue, iterate in BUSY, publish result leaving FIX
  always_comb begin
    op_d     = op_q;
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (!md.cancel) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_d     = md_op_e'(md.opE);
            negRes_d = signA ^ signB;
            negRem_d = signA;
            opnd_d   = startIsDiv ? magB : magA;
            acc_d    = {{WIDTH{1'b0}}, (startIsDiv ? magA : magB)};
            if (startDivZero) begin
              hi_d = md.srcaE;
              lo_d = '1;
            end
          end
        end
        S_BUSY: acc_d = opIsDiv ? divNext : mulNext;
        S_FIX: begin
          if (opIsDiv) begin
            hi_d = remFix;
            lo_d = quotFix;
          end else begin
            hi_d = prodFix[2*WIDTH-1:WIDTH];
            lo_d = prodFix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: each task drives one scenario and checks
// hand-computed cycle counts and HI/LO values.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  muldiv_seq_if #(.WIDTH(32)) mdIf ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .md  (mdIf)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op at the current cycle and watch until done or the budget expires.
  // Called at posedge+1; returns at posedge+1 of the cycle after done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int maxC, output int doneAt, output int stallCnt,
                        output bit contig, output logic [31:0] hiAt, output logic [31:0] loAt);
    bit sawLow;
    doneAt   = -1;
    stallCnt = 0;
    contig   = 1'b1;
    sawLow   = 1'b0;
    hiAt     = '0;
    loAt     = '0;
    mdIf.startE = 1'b1;
    mdIf.opE    = op;
    mdIf.srcaE  = a;
    mdIf.srcbE  = b;
    for (int k = 0; k <= maxC; k++) begin
      #1;
      if (mdIf.stall_mdE) begin
        stallCnt++;
        if (sawLow) contig = 1'b0;
      end else begin
        sawLow = 1'b1;
      end
      if (mdIf.done && doneAt < 0) begin
        doneAt = k;
        hiAt   = mdIf.hi;
        loAt   = mdIf.lo;
      end
      @(posedge clk);
      #1;
      mdIf.startE = 1'b0;
      if (doneAt >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    mdIf.startE = 1'b0;
    mdIf.opE    = 2'b00;
    mdIf.srcaE  = '0;
    mdIf.srcbE  = '0;
    mdIf.cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mdIf.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", mdIf.busy); end
    checks++; if (mdIf.stall_mdE !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b exp=0", mdIf.stall_mdE); end
    checks++; if (mdIf.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", mdIf.done); end
    checks++; if (mdIf.hi !== 32'h0) begin failures++; $display("[TB] FAIL reset_hi got=%h exp=0", mdIf.hi); end
    checks++; if (mdIf.lo !== 32'h0) begin failures++; $display("[TB] FAIL reset_lo got=%h exp=0", mdIf.lo); end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_multu_max();
    int doneAt, stallCnt;
    bit contig;
    logic [31:0] h, l;
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40, doneAt, stallCnt, contig, h, l);
    checks++; if (doneAt != 34) begin failures++; $display("[TB] FAIL multu_done_cycle got=%0d exp=34", doneAt); end
    checks++; if (stallCnt != 34) begin failures++; $display("[TB] FAIL multu_stall_cycles got=%0d exp=34", stallCnt); end
    checks++; if (contig !== 1'b1) begin failures++; $display("[TB] FAIL multu_stall_window got=split exp=contiguous"); end
    checks++; if (h !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL multu_hi got=%h exp=fffffffe", h); end
    checks++; if (l !== 32'h0000_0001) begin failures++; $display("[TB] FAIL multu_lo got=%h exp=00000001", l); end
  endtask

  task automatic test_back_to_back();
    int doneAt, stallCnt;
    bit contig;
    logic [31:0] h, l;
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 40, doneAt, stallCnt, contig, h, l);
    checks++; if (doneAt != 34) begin failures++; $display("[TB] FAIL mult_done_cycle got=%0d exp=34", doneAt); end
    checks++; if (h !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mult_hi got=%h exp=ffffffff", h); end
    checks++; if (l !== 32'hFFFF_FFEB) begin failures++; $display("[TB] FAIL mult_lo got=%h exp=ffffffeb", l); end
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 40, doneAt, stallCnt, contig, h, l);
    checks++; if (doneAt != 34) begin failures++; $display("[TB] FAIL div_b2b_done_cycle got=%0d exp=34", doneAt); end
    checks++; if (l !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_b2b_lo got=%h exp=fffffffd", l); end
    checks++; if (h !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div_b2b_hi got=%h exp=ffffffff", h); end
  endtask

  task automatic test_div_zero();
    int doneAt, stallCnt;
    bit contig;
    logic [31:0] h, l;
    run_op(MD_DIVU, 32'd100, 32'd0, 10, doneAt, stallCnt, contig, h, l);
    checks++; if (doneAt != 1) begin failures++; $display("[TB] FAIL div0_done_cycle got=%0d exp=1", doneAt); end
    checks++; if (stallCnt != 1) begin failures++; $display("[TB] FAIL div0_stall_cycles got=%0d exp=1", stallCnt); end
    checks++; if (l !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div0_lo got=%h exp=ffffffff", l); end
    checks++; if (h !== 32'h0000_0064) begin failures++; $display("[TB] FAIL div0_hi got=%h exp=00000064", h); end
    #1;
    checks++; if (mdIf.done !== 1'b0) begin failures++; $display("[TB] FAIL div0_done_pulse got=%b exp=0", mdIf.done); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_div_overflow();
    int doneAt, stallCnt;
    bit contig;
    logic [31:0] h, l;
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 40, doneAt, stallCnt, contig, h, l);
    checks++; if (doneAt != 34) begin failures++; $display("[TB] FAIL divovf_done_cycle got=%0d exp=34", doneAt); end
    checks++; if (l !== 32'h8000_0000) begin failures++; $display("[TB] FAIL divovf_lo got=%h exp=80000000", l); end
    checks++; if (h !== 32'h0000_0000) begin failures++; $display("[TB] FAIL divovf_hi got=%h exp=00000000", h); end
  endtask

  task automatic test_cancel();
    int doneAt, stallCnt;
    bit contig;
    bit sawDone;
    logic [31:0] h, l;
    // Start DIVU 1000/7 and cancel it in its 10th BUSY cycle
    mdIf.startE = 1'b1;
    mdIf.opE    = MD_DIVU;
    mdIf.srcaE  = 32'd1000;
    mdIf.srcbE  = 32'd7;
    @(posedge clk);
    #1;
    mdIf.startE = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    mdIf.cancel = 1'b1;
    #1;
    checks++; if (mdIf.stall_mdE !== 1'b0) begin failures++; $display("[TB] FAIL cancel_stall got=%b exp=0", mdIf.stall_mdE); end
    checks++; if (mdIf.busy !== 1'b1) begin failures++; $display("[TB] FAIL cancel_busy_before got=%b exp=1", mdIf.busy); end
    @(posedge clk);
    #1;
    mdIf.cancel = 1'b0;
    checks++; if (mdIf.busy !== 1'b0) begin failures++; $display("[TB] FAIL cancel_idle got=%b exp=0", mdIf.busy); end
    sawDone = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (mdIf.done) sawDone = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++; if (sawDone !== 1'b0) begin failures++; $display("[TB] FAIL cancel_no_done got=%b exp=0", sawDone); end
    checks++; if (mdIf.hi !== 32'h0000_0000) begin failures++; $display("[TB] FAIL cancel_hi_kept got=%h exp=00000000", mdIf.hi); end
    checks++; if (mdIf.lo !== 32'h8000_0000) begin failures++; $display("[TB] FAIL cancel_lo_kept got=%h exp=80000000", mdIf.lo); end
    run_op(MD_DIVU, 32'd1000, 32'd7, 40, doneAt, stallCnt, contig, h, l);
    checks++; if (doneAt != 34) begin failures++; $display("[TB] FAIL restart_done_cycle got=%0d exp=34", doneAt); end
    checks++; if (l !== 32'd142) begin failures++; $display("[TB] FAIL restart_lo got=%0d exp=142", l); end
    checks++; if (h !== 32'd6) begin failures++; $display("[TB] FAIL restart_hi got=%0d exp=6", h); end
  endtask

  task automatic test_reset_mid_busy();
    int doneAt, stallCnt;
    bit contig;
    logic [31:0] h, l;
    mdIf.startE = 1'b1;
    mdIf.opE    = MD_MULTU;
    mdIf.srcaE  = 32'h1234_5678;
    mdIf.srcbE  = 32'h0000_0011;
    @(posedge clk);
    #1;
    mdIf.startE = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checks++; if (mdIf.busy !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_busy_before got=%b exp=1", mdIf.busy); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (mdIf.busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b exp=0", mdIf.busy); end
    checks++; if (mdIf.stall_mdE !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_stall got=%b exp=0", mdIf.stall_mdE); end
    checks++; if (mdIf.hi !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_hi got=%h exp=0", mdIf.hi); end
    checks++; if (mdIf.lo !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_lo got=%h exp=0", mdIf.lo); end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(MD_MULTU, 32'd3, 32'd5, 40, doneAt, stallCnt, contig, h, l);
    checks++; if (doneAt != 34) begin failures++; $display("[TB] FAIL rstmid_multu_done got=%0d exp=34", doneAt); end
    checks++; if (l !== 32'd15) begin failures++; $display("[TB] FAIL rstmid_multu_lo got=%0d exp=15", l); end
    checks++; if (h !== 32'd0) begin failures++; $display("[TB] FAIL rstmid_multu_hi got=%0d exp=0", h); end
  endtask

  // Scenario sequence; later tasks rely on the HI/LO left behind by earlier ones
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_multu_max();
    test_back_to_back();
    test_div_zero();
    test_div_overflow();
    test_cancel();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
